sram_bus_arbiter: RTL
=====================

# sram_bus_arbiter

Shares the single external asynchronous SRAM of the minimal SOPC between the CPU instruction bus (read-only) and data bus (read/write). The block arbitrates the two Wishbone-style slave ports, sequences SRAM chip-enable, output-enable and write-enable with a parameterised number of wait states, and returns one-cycle acknowledges. It sits between the `openmips` core bus ports and the SRAM pins at the SOPC top level.

## Interface
- ADDR_W, 20, SRAM word-address width; master byte address bits [ADDR_W+1:2] map to `sram_addr`.
- WAIT_CYC, 1, extra SRAM access cycles; legal range 0..15.

- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_cyc_i / i_stb_i  in  1 / 1  instruction-bus cycle / strobe
- i_adr_i  in  32  instruction byte address
- i_dat_o  out  32  instruction read data
- i_ack_o  out  1  instruction acknowledge
- d_cyc_i / d_stb_i / d_we_i  in  1 / 1 / 1  data-bus cycle / strobe / write
- d_sel_i  in  4  data byte selects
- d_adr_i  in  32  data byte address
- d_dat_i  in  32  data write data
- d_dat_o  out  32  data read data
- d_ack_o  out  1  data acknowledge
- sram_ce_n / sram_oe_n / sram_we_n  out  1 / 1 / 1  SRAM strobes, active-low
- sram_be_n  out  4  SRAM byte enables, active-low
- sram_addr  out  ADDR_W  SRAM word address
- sram_dq_o  out  32  SRAM write data
- sram_dq_oe  out  1  write-data drive enable (tristate control at top level)
- sram_dq_i  in  32  SRAM read data

## Operation
- A master requests when cyc & stb are high. All SRAM outputs and acks are registered.
- FSM states: IDLE, ACCESS, ACK.
- IDLE: if any request, pick a winner, latch address/we/sel/wdata into SRAM output registers, load wait counter with WAIT_CYC, go ACCESS. No request: stay.
- Arbitration: data bus has priority, except when the last grant was data and the instruction bus is requesting, in which case instruction wins (strict alternation under continuous contention). `last_grant` resets to instruction.
- ACCESS: `sram_ce_n`=0. Read: `sram_oe_n`=0, `sram_be_n`=4'h0. Write: `sram_we_n`=0, `sram_be_n`=~d_sel_i (latched), `sram_dq_oe`=1, `sram_dq_o`=latched wdata. Counter decrements each cycle; at 0 go ACK; on read, `sram_dq_i` is captured into the shared read-data register on that edge.
- ACK: all strobes high, `sram_dq_oe`=0, address held. Winner's ack is high exactly this cycle only if its cyc is still high; otherwise ack is suppressed (aborted cycle still completes on SRAM). Return to IDLE.
- `i_dat_o` and `d_dat_o` both drive the shared read-data register; valid while the corresponding ack is high, held until next read.
- Instruction requests with any write intent do not exist (port is read-only); data writes with `d_sel_i`=0 still run a full cycle with `sram_be_n`=4'hF.
- Requests changing during ACCESS/ACK are ignored; latched values govern the transaction.

## Timing
- Reset (rst_n sampled low): next edge state=IDLE, `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1, `sram_be_n`=4'hF, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, acks=0, read data=0, last_grant=instruction. Reset mid-ACCESS aborts with no ack.
- Request sampled in IDLE at edge 0 -> ACCESS during cycles 1..WAIT_CYC+1 -> ACK during cycle WAIT_CYC+2.
- Latency request-to-ack: WAIT_CYC+2 cycles; throughput one transaction per WAIT_CYC+3 cycles (ACK always returns to IDLE).
- Address and write data stable from first ACCESS cycle through ACK; `sram_we_n` deasserts one cycle before address may change.
- Master must hold stb until ack or drop cyc to abort.

## Test plan
- Reset: hold rst_n low 3 cycles during pending requests -> all SRAM strobes 1, be_n 4'hF, acks 0; no SRAM cycle.
- Instruction read, WAIT_CYC=1, i_adr_i=32'h0000_0010, SRAM model returns 32'h3401_1100 -> sram_addr=4 in cycles 1-2, oe_n low 2 cycles, i_ack_o in cycle 3 with i_dat_o=32'h3401_1100.
- Data byte write d_adr_i=32'h0000_0104, d_sel_i=4'b0010, d_dat_i=32'h0000_AB00 -> we_n low 2 cycles, be_n=4'b1101, dq_oe high, addr=65; readback returns 8'hAB in byte 1.
- Both buses request continuously -> grants alternate D,I,D,I...; first grant data; no ack to wrong port.
- Abort: data read, d_cyc_i dropped in second ACCESS cycle -> SRAM cycle completes, d_ack_o stays 0, next pending instruction request served.
- WAIT_CYC=0 sweep and WAIT_CYC=3 -> ack exactly WAIT_CYC+2 cycles after request.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//   Shares one external asynchronous SRAM between the CPU instruction bus
//   (read-only) and data bus (read/write). Each transaction runs
//   IDLE -> ACCESS (WAIT_CYC+1 cycles) -> ACK (1 cycle) -> IDLE.
//   Every SRAM pin and both acks come straight from flops.
//
// Parameters
//   ADDR_W    SRAM word-address width (master byte address bits [ADDR_W+1:2])
//   WAIT_CYC  extra SRAM access cycles, 0..15
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   i_cyc_i/i_stb_i/i_adr_i    instruction bus request
//   i_dat_o/i_ack_o            instruction read data / acknowledge
//   d_cyc_i/d_stb_i/d_we_i     data bus request
//   d_sel_i/d_adr_i/d_dat_i    data byte selects / address / write data
//   d_dat_o/d_ack_o            data read data / acknowledge
//   sram_ce_n/oe_n/we_n/be_n   SRAM strobes, active-low
//   sram_addr                  SRAM word address
//   sram_dq_o/sram_dq_oe       SRAM write data and its drive enable
//   sram_dq_i                  SRAM read data
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cyc_i,
    input  logic              i_stb_i,
    input  logic [31:0]       i_adr_i,
    output logic [31:0]       i_dat_o,
    output logic              i_ack_o,
    input  logic              d_cyc_i,
    input  logic              d_stb_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic [31:0]       d_adr_i,
    input  logic [31:0]       d_dat_i,
    output logic [31:0]       d_dat_o,
    output logic              d_ack_o,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    localparam logic [3:0] WAIT_LD = WAIT_CYC[3:0];

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        gnt_d;       // current transaction belongs to the data bus
    logic        last_gnt_d;  // previous grant went to the data bus
    logic        acc_we;      // current transaction is a write
    logic [31:0] rdata;       // shared read-data register

    logic i_req;
    logic d_req;
    logic pick_d;

    assign i_req = i_cyc_i & i_stb_i;
    assign d_req = d_cyc_i & d_stb_i;

    // Data has priority unless it also had the previous grant and the
    // instruction bus is waiting: gives strict alternation under contention.
    assign pick_d = d_req & ~(last_gnt_d & i_req);

    assign i_dat_o = rdata;
    assign d_dat_o = rdata;

    // Address bits outside the SRAM word range are intentionally ignored.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, i_adr_i[31:ADDR_W+2], i_adr_i[1:0],
                               d_adr_i[31:ADDR_W+2], d_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            gnt_d      <= 1'b0;
            last_gnt_d <= 1'b0;
            acc_we     <= 1'b0;
            rdata      <= '0;
            i_ack_o    <= 1'b0;
            d_ack_o    <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'hF;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    i_ack_o <= 1'b0;
                    d_ack_o <= 1'b0;
                    if (i_req || d_req) begin
                        state      <= S_ACCESS;
                        wait_cnt   <= WAIT_LD;
                        gnt_d      <= pick_d;
                        last_gnt_d <= pick_d;
                        sram_ce_n  <= 1'b0;
                        if (pick_d) begin
                            sram_addr <= d_adr_i[ADDR_W+1:2];
                            acc_we    <= d_we_i;
                            if (d_we_i) begin
                                sram_we_n  <= 1'b0;
                                sram_oe_n  <= 1'b1;
                                sram_be_n  <= ~d_sel_i;
                                sram_dq_o  <= d_dat_i;
                                sram_dq_oe <= 1'b1;
                            end else begin
                                sram_we_n  <= 1'b1;
                                sram_oe_n  <= 1'b0;
                                sram_be_n  <= 4'h0;
                                sram_dq_oe <= 1'b0;
                            end
                        end else begin
                            // instruction port is read-only
                            sram_addr  <= i_adr_i[ADDR_W+1:2];
                            acc_we     <= 1'b0;
                            sram_we_n  <= 1'b1;
                            sram_oe_n  <= 1'b0;
                            sram_be_n  <= 4'h0;
                            sram_dq_oe <= 1'b0;
                        end
                    end
                end

                S_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state      <= S_ACK;
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_be_n  <= 4'hF;
                        sram_dq_oe <= 1'b0;
                        if (!acc_we)
                            rdata <= sram_dq_i;
                        // A master that dropped cyc has aborted: the SRAM
                        // cycle still finishes but no ack is returned.
                        if (gnt_d)
                            d_ack_o <= d_cyc_i;
                        else
                            i_ack_o <= i_cyc_i;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                S_ACK: begin
                    i_ack_o <= 1'b0;
                    d_ack_o <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
